fft_seq: RTL and testbench

FFT_SEQ -- requirements
Module: fft_seq

---
 rtl/fft_seq_if.sv | 23 ++
 rtl/fft_seq.sv | 138 +++++++++++++
 tb/tb_fft_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_if.sv
// fft_seq_if: sample handshake and pipeline control bundle of the FFT sequencer.
interface fft_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        en_o;
  logic [4:0]  stage_mode;
  logic [19:0] tw_idx;
  logic        out_valid;
  logic        out_sop;
  logic        busy;

  // Upstream source / pipeline consumer side
  modport master (
    output in_valid,
    input  in_ready, en_o, stage_mode, tw_idx, out_valid, out_sop, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    output in_ready, en_o, stage_mode, tw_idx, out_valid, out_sop, busy
  );
endinterface

// File: rtl/fft_seq.sv
// fft_seq: control sequencer for a 32-point radix-2 single-path delay-feedback FFT.
// One shared sample counter drives all five stages; each stage sees it shifted by
// its pipeline offset and decides butterfly phase and twiddle index from that.
module fft_seq (
  input  logic     clk,
  input  logic     rst_n,
  fft_seq_if.slave bus
);
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FILL_W = 6;
  localparam int unsigned NSTAGE = 5;
  localparam int unsigned TW_W   = 4;

  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(36);
  localparam logic [FILL_W-1:0] DRAIN_LAST = FILL_W'(35);
  localparam logic [CNT_W-1:0]  SOP_CNT    = CNT_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [FILL_W-1:0]      dcnt_q, dcnt_d;
  logic                   en_c;
  logic                   full_c;
  logic [NSTAGE-1:0]      mode_c;
  logic [TW_W*NSTAGE-1:0] tw_c;

  // Pipeline offset of each stage relative to the input sample count
  function automatic logic [FILL_W-1:0] stage_off(input int k);
    case (k)
      0:       return FILL_W'(0);
      1:       return FILL_W'(17);
      2:       return FILL_W'(26);
      3:       return FILL_W'(31);
      default: return FILL_W'(34);
    endcase
  endfunction

  // Counter values after one pipeline advance; fill saturates once every stage holds data
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
    dcnt_d = dcnt_q + FILL_W'(1);
  end

  // Sequencer: accept samples, hold on stalls, drain the pipeline after a frame-aligned gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_q <= S_RUN;
            cnt_q   <= CNT_W'(1);
            fill_q  <= FILL_W'(1);
          end
        end
        S_RUN: begin
          if (bus.in_valid) begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
          end else if (cnt_q == '0) begin
            state_q <= S_DRAIN;
            dcnt_q  <= '0;
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DRAIN_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            dcnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            dcnt_q <= dcnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pipeline advance: one shift per accepted sample, free-running while draining
  always_comb begin
    en_c = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: en_c = bus.in_valid;
      S_DRAIN:       en_c = 1'b1;
      default:       en_c = 1'b0;
    endcase
  end

  // Per-stage butterfly phase and twiddle index from the offset-adjusted sample count
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam logic [FILL_W-1:0] OFF = stage_off(k);
    localparam int unsigned       CW  = CNT_W - k;
    logic [CW-1:0] c_loc;
    logic          active;
    logic          mode;

    assign c_loc = CW'(cnt_q - OFF[CNT_W-1:0]);

    if (k == 0) begin : g_act_first
      assign active = 1'b1;
    end else begin : g_act
      assign active = (fill_q >= OFF);
    end

    assign mode      = active && c_loc[CW-1];
    assign mode_c[k] = mode;

    if (k < NSTAGE - 1) begin : g_tw
      assign tw_c[TW_W*k +: TW_W] = mode ? (TW_W'(c_loc[CW-2:0]) << k) : '0;
    end else begin : g_no_tw
      assign tw_c[TW_W*k +: TW_W] = '0;
    end
  end

  assign full_c = (fill_q == FILL_MAX);

  assign bus.in_ready   = (state_q != S_DRAIN);
  assign bus.en_o       = en_c;
  assign bus.stage_mode = mode_c;
  assign bus.tw_idx     = tw_c;
  assign bus.out_valid  = en_c && full_c;
  assign bus.out_sop    = en_c && full_c && (cnt_q == SOP_CNT);
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_fft_seq.sv
// tb_fft_seq: directed vectors plus randomized streams against a count-based reference model.
module tb_fft_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fft_seq_if bus ();
  assign bus.in_valid = in_valid;

  fft_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic [4:0]  mode;
    logic [19:0] tw;
    logic        ov;
    logic        sop;
    logic        busy;
  } obs_t;

  typedef struct {
    int          e;
    logic [4:0]  mode;
    logic [19:0] tw;
    logic        ov;
    logic        sop;
  } vec_t;

  // Reference model: phase (0 idle, 1 run, 2 drain) and e = en cycles seen in the stream
  int m_phase = 0;
  int m_e     = 0;
  int m_end_e = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_e     <= 0;
      m_end_e <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin m_phase <= 1; m_e <= 1; end
        1: begin
          if (in_valid) m_e <= m_e + 1;
          else if (m_e % 32 == 0) begin m_phase <= 2; m_end_e <= m_e; end
        end
        default: begin
          if (m_e + 1 == m_end_e + 36) begin m_phase <= 0; m_e <= 0; end
          else m_e <= m_e + 1;
        end
      endcase
    end
  end

  // Expected outputs: stage k sees sample (e - D_k); it is in butterfly phase in the
  // upper half of each 2*L_k block, twiddle = position within that half scaled to W32.
  function automatic obs_t model_out(input int ph, input int e, input logic iv);
    obs_t o;
    int   d [5];
    int   c;
    int   l;
    d = '{0, 17, 26, 31, 34};
    o = '0;
    o.rdy  = (ph != 2);
    o.en   = (ph == 2) ? 1'b1 : iv;
    o.busy = (ph != 0);
    for (int k = 0; k < 5; k++) begin
      l = 16 >> k;
      c = (((e - d[k]) % 32) + 32) % 32;
      if (e >= d[k] && ((c / l) % 2 == 1)) begin
        o.mode[k] = 1'b1;
        if (k < 4) o.tw[4*k +: 4] = 4'((c % l) * (1 << k));
      end
    end
    o.ov  = o.en && (e >= 36);
    o.sop = o.ov && ((e - 36) % 32 == 0);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    obs_t x;
    obs_t a;
    x = model_out(m_phase, m_e, in_valid);
    a = {bus.in_ready, bus.en_o, bus.stage_mode, bus.tw_idx, bus.out_valid, bus.out_sop, bus.busy};
    chk("model_in_ready",   int'(a.rdy),  int'(x.rdy));
    chk("model_en_o",       int'(a.en),   int'(x.en));
    chk("model_stage_mode", int'(a.mode), int'(x.mode));
    chk("model_tw_idx",     int'(a.tw),   int'(x.tw));
    chk("model_out_valid",  int'(a.ov),   int'(x.ov));
    chk("model_out_sop",    int'(a.sop),  int'(x.sop));
    chk("model_busy",       int'(a.busy), int'(x.busy));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},   int'(bus.in_ready),   1);
    chk({tag, "_en_o"},       int'(bus.en_o),       0);
    chk({tag, "_stage_mode"}, int'(bus.stage_mode), 0);
    chk({tag, "_tw_idx"},     int'(bus.tw_idx),     0);
    chk({tag, "_out_valid"},  int'(bus.out_valid),  0);
    chk({tag, "_out_sop"},    int'(bus.out_sop),    0);
    chk({tag, "_busy"},       int'(bus.busy),       0);
  endtask

  task automatic drive(input logic iv);
    in_valid = iv;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [15];
    int   en_cnt, first_ov, first_sop, n_ov, n_sop, n_low, done_cyc, hit;
    int   first_low, last_low, thr;
    int   sop_en [4];

    vecs[0]  = '{0,  5'b00000, 20'h00000, 1'b0, 1'b0};
    vecs[1]  = '{15, 5'b00000, 20'h00000, 1'b0, 1'b0};
    vecs[2]  = '{16, 5'b00001, 20'h00000, 1'b0, 1'b0};
    vecs[3]  = '{17, 5'b00001, 20'h00001, 1'b0, 1'b0};
    vecs[4]  = '{23, 5'b00001, 20'h00007, 1'b0, 1'b0};
    vecs[5]  = '{25, 5'b00011, 20'h00009, 1'b0, 1'b0};
    vecs[6]  = '{26, 5'b00011, 20'h0002A, 1'b0, 1'b0};
    vecs[7]  = '{31, 5'b00111, 20'h004CF, 1'b0, 1'b0};
    vecs[8]  = '{32, 5'b00110, 20'h008E0, 1'b0, 1'b0};
    vecs[9]  = '{35, 5'b10000, 20'h00000, 1'b0, 1'b0};
    vecs[10] = '{36, 5'b00000, 20'h00000, 1'b1, 1'b1};
    vecs[11] = '{40, 5'b00100, 20'h00800, 1'b1, 1'b0};
    vecs[12] = '{43, 5'b10010, 20'h00040, 1'b1, 1'b0};
    vecs[13] = '{47, 5'b10110, 20'h004C0, 1'b1, 1'b0};
    vecs[14] = '{68, 5'b00000, 20'h00000, 1'b1, 1'b1};

    // Reset values, during and after reset
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_idle("rst_during");
    tick();
    do_reset();
    drive(1'b0);
    check_idle("rst_after");
    tick();

    // Single frame: latency, output count, drain length
    do_reset();
    en_cnt = 0; first_ov = -1; first_sop = -1; n_ov = 0; n_sop = 0; n_low = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      drive(cyc < 32);
      if (bus.en_o) en_cnt++;
      if (bus.out_valid) begin n_ov++; if (first_ov < 0) first_ov = en_cnt; end
      if (bus.out_sop) begin n_sop++; if (first_sop < 0) first_sop = en_cnt; end
      if (!bus.in_ready) n_low++;
      if (cyc > 0 && !bus.busy) begin done_cyc = cyc; break; end
      tick();
    end
    chk("sf_first_out_valid_en", first_ov, 37);
    chk("sf_first_out_sop_en", first_sop, 37);
    chk("sf_out_valid_count", n_ov, 32);
    chk("sf_out_sop_count", n_sop, 1);
    chk("sf_drain_cycles", n_low, 36);
    chk("sf_idle_cycle", done_cyc, 69);
    tick();

    // Table vectors: stage phase/twiddle at chosen en cycles of a continuous stream
    for (int i = 0; i < 15; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].e; j++) begin
        drive(1'b1);
        tick();
      end
      drive(1'b1);
      chk($sformatf("vec%0d_e%0d_stage_mode", i, vecs[i].e), int'(bus.stage_mode), int'(vecs[i].mode));
      chk($sformatf("vec%0d_e%0d_tw_idx", i, vecs[i].e), int'(bus.tw_idx), int'(vecs[i].tw));
      chk($sformatf("vec%0d_e%0d_out_valid", i, vecs[i].e), int'(bus.out_valid), int'(vecs[i].ov));
      chk($sformatf("vec%0d_e%0d_out_sop", i, vecs[i].e), int'(bus.out_sop), int'(vecs[i].sop));
      tick();
    end

    // Mid-frame stall at cnt=10 of the second frame
    do_reset();
    for (int j = 0; j < 42; j++) begin
      drive(1'b1);
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b0);
      chk($sformatf("stall%0d_en_o", s), int'(bus.en_o), 0);
      chk($sformatf("stall%0d_stage_mode", s), int'(bus.stage_mode), 5'b01010);
      chk($sformatf("stall%0d_tw_idx", s), int'(bus.tw_idx), 20'h08020);
      chk($sformatf("stall%0d_out_valid", s), int'(bus.out_valid), 0);
      chk($sformatf("stall%0d_busy", s), int'(bus.busy), 1);
      tick();
    end
    drive(1'b1);
    chk("resume_en_o", int'(bus.en_o), 1);
    chk("resume_stage_mode", int'(bus.stage_mode), 5'b01010);
    chk("resume_tw_idx", int'(bus.tw_idx), 20'h08020);
    chk("resume_out_valid", int'(bus.out_valid), 1);
    tick();
    drive(1'b1);
    chk("resume_next_stage_mode", int'(bus.stage_mode), 5'b10010);
    chk("resume_next_tw_idx", int'(bus.tw_idx), 20'h00040);
    tick();

    // Back-to-back frames
    do_reset();
    en_cnt = 0; n_sop = 0; n_low = 0; first_low = -1; last_low = -1; done_cyc = -1;
    sop_en = '{0, 0, 0, 0};
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive(cyc < 96);
      if (bus.en_o) en_cnt++;
      if (bus.out_sop) begin
        if (n_sop < 4) sop_en[n_sop] = en_cnt;
        n_sop++;
      end
      if (!bus.in_ready) begin
        n_low++;
        if (first_low < 0) first_low = cyc;
        last_low = cyc;
      end
      if (cyc > 0 && !bus.busy) begin done_cyc = cyc; break; end
      tick();
    end
    chk("b2b_sop_count", n_sop, 3);
    chk("b2b_first_sop_en", sop_en[0], 37);
    chk("b2b_sop_gap1", sop_en[1] - sop_en[0], 32);
    chk("b2b_sop_gap2", sop_en[2] - sop_en[1], 32);
    chk("b2b_ready_low_count", n_low, 36);
    chk("b2b_ready_low_first", first_low, 97);
    chk("b2b_ready_low_span", last_low - first_low + 1, 36);
    chk("b2b_idle_cycle", done_cyc, 133);
    tick();

    // Asynchronous reset in the middle of the drain
    do_reset();
    hit = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      drive(cyc < 32);
      if (cyc == 53) begin
        chk("rd_pre_in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        check_idle("rd_reset");
        hit = 1;
        break;
      end
      tick();
    end
    chk("rd_reached", hit, 1);
    tick();
    tick();
    rst_n = 1'b1;
    en_cnt = 0; first_sop = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      drive(1'b1);
      if (bus.en_o) en_cnt++;
      if (bus.out_sop) begin first_sop = en_cnt; break; end
      tick();
    end
    chk("rd_restart_first_sop_en", first_sop, 37);
    tick();

    // Randomized streams with stalls, stream ends and occasional resets
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       thr = 4;
        1:       thr = 20;
        default: thr = 100;
      endcase
      if ($urandom_range(0, 249) == 0) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      drive($urandom_range(0, thr - 1) != 0);
      tick();
    end

    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
